// File: rtl/cla_pkg.sv
// Shared types and the 4-bit group propagate/generate helper for the pipelined CLA adder.
package cla_pkg;

  localparam int CLA_GRP_W = 4;

  typedef struct packed {
    logic p;
    logic g;
  } cla_pg_t;

  function automatic cla_pg_t cla_grp_pg(input logic [CLA_GRP_W-1:0] p,
                                         input logic [CLA_GRP_W-1:0] g);
    cla_pg_t r;
    r.p = &p;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result streaming bus of the pipelined CLA adder (ovf exists only with CLA_OVF_EN).
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_OVF_EN
  logic             ovf;

  modport master (output in_valid, ain, bin, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, ain, bin, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, ain, bin, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, ain, bin, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead slice: sum plus group propagate/generate.
module cla_group4
  import cla_pkg::*;
(
  input  logic [CLA_GRP_W-1:0] a_i,
  input  logic [CLA_GRP_W-1:0] b_i,
  input  logic                 ci_i,
  output logic [CLA_GRP_W-1:0] sum_o,
  output logic                 p_o,
  output logic                 g_o
);

  logic [CLA_GRP_W-1:0] p_s;
  logic [CLA_GRP_W-1:0] g_s;
  logic [CLA_GRP_W-1:0] c_s;
  cla_pg_t              pg_s;

  assign p_s = a_i ^ b_i;
  assign g_s = a_i & b_i;

  assign c_s[0] = ci_i;
  assign c_s[1] = g_s[0] | (p_s[0] & ci_i);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci_i);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & ci_i);

  assign sum_o = p_s ^ c_s;
  assign pg_s  = cla_grp_pg(p_s, g_s);
  assign p_o   = pg_s.p;
  assign g_o   = pg_s.g;

endmodule

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit pipelined carry-lookahead adder/subtractor, GPS 4-bit groups per stage.
// Optional signed-overflow output enabled by defining CLA_OVF_EN.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GPS   = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  pipelined_cla_adder_if.slave bus
);

  localparam int SW     = CLA_GRP_W * GPS;
  localparam int NSTAGE = WIDTH / SW;

  if (((WIDTH % SW) != 0) || (WIDTH < SW)) begin : gen_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a nonzero multiple of 4*GPS");
  end

  logic             en_s;
  logic             c0_s;
  logic [WIDTH-1:0] b_eff_s;

  // One global advance: the whole pipe shifts or the whole pipe holds.
  assign en_s         = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = en_s;
  assign b_eff_s      = bus.sub ? ~bus.bin : bus.bin;
  assign c0_s         = bus.sub | bus.cin;

  for (genvar k = 0; k < NSTAGE; k++) begin : gen_stg
    localparam int LO = k * SW;
    localparam int HI = LO + SW - 1;

    logic [WIDTH-1:LO] a_up_s;
    logic [WIDTH-1:LO] b_up_s;
    logic [HI:0]       sum_new_s;
    logic [SW-1:0]     s_s;
    logic [GPS-1:0]    gp_s;
    logic [GPS-1:0]    gg_s;
    logic [GPS:0]      c_s;
    logic              ci_s;
    logic              vi_s;
    logic              vld_d, vld_q;
    logic              co_d, co_q;
    logic [HI:0]       sum_d, sum_q;

    if (k == 0) begin : gen_src
      assign a_up_s    = bus.ain;
      assign b_up_s    = b_eff_s;
      assign ci_s      = c0_s;
      assign vi_s      = bus.in_valid;
      assign sum_new_s = s_s;
    end else begin : gen_src
      assign a_up_s    = gen_stg[k-1].gen_skew.a_q;
      assign b_up_s    = gen_stg[k-1].gen_skew.b_q;
      assign ci_s      = gen_stg[k-1].co_q;
      assign vi_s      = gen_stg[k-1].vld_q;
      assign sum_new_s = {s_s, gen_stg[k-1].sum_q};
    end

    for (genvar j = 0; j < GPS; j++) begin : gen_grp
      cla_group4 u_grp (
        .a_i   (a_up_s[LO + j*CLA_GRP_W +: CLA_GRP_W]),
        .b_i   (b_up_s[LO + j*CLA_GRP_W +: CLA_GRP_W]),
        .ci_i  (c_s[j]),
        .sum_o (s_s[j*CLA_GRP_W +: CLA_GRP_W]),
        .p_o   (gp_s[j]),
        .g_o   (gg_s[j])
      );
    end

    // Flat group-level lookahead: each group carry is a sum of products of group P/G and ci.
    always_comb begin : p_lookahead
      logic term_s;
      logic pall_s;
      c_s    = '0;
      term_s = 1'b0;
      pall_s = 1'b1;
      c_s[0] = ci_s;
      for (int j = 0; j < GPS; j++) begin
        term_s = 1'b0;
        pall_s = 1'b1;
        for (int i = j; i >= 0; i--) begin
          term_s = term_s | (pall_s & gg_s[i]);
          pall_s = pall_s & gp_s[i];
        end
        c_s[j+1] = term_s | (pall_s & ci_s);
      end
    end

    // Stage next-state: shift on advance, hold otherwise.
    always_comb begin
      vld_d = vld_q;
      co_d  = co_q;
      sum_d = sum_q;
      if (en_s) begin
        vld_d = vi_s;
        co_d  = c_s[GPS];
        sum_d = sum_new_s;
      end else begin
        vld_d = vld_q;
        co_d  = co_q;
        sum_d = sum_q;
      end
    end

    // Stage valid, carry and de-skewed low sum bits.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        co_q  <= 1'b0;
        sum_q <= '0;
      end else begin
        vld_q <= vld_d;
        co_q  <= co_d;
        sum_q <= sum_d;
      end
    end

    if (k < NSTAGE - 1) begin : gen_skew
      logic [WIDTH-1:HI+1] a_d, a_q;
      logic [WIDTH-1:HI+1] b_d, b_q;

      // Upper operand bits wait here until their stage is reached.
      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (en_s) begin
          a_d = a_up_s[WIDTH-1:HI+1];
          b_d = b_up_s[WIDTH-1:HI+1];
        end else begin
          a_d = a_q;
          b_d = b_q;
        end
      end

      // Skew registers for not-yet-added operand bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef CLA_OVF_EN
    if (k == NSTAGE - 1) begin : gen_ovf
      logic ovf_d, ovf_q;

      // Signed overflow from operand and result sign bits, using the effective B.
      always_comb begin
        ovf_d = ovf_q;
        if (en_s) begin
          ovf_d = (a_up_s[WIDTH-1] == b_up_s[WIDTH-1]) & (s_s[SW-1] != a_up_s[WIDTH-1]);
        end else begin
          ovf_d = ovf_q;
        end
      end

      // Overflow flag travels with the final sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign bus.out_valid = gen_stg[NSTAGE-1].vld_q;
  assign bus.sum       = gen_stg[NSTAGE-1].sum_q;
  assign bus.cout      = gen_stg[NSTAGE-1].co_q;
`ifdef CLA_OVF_EN
  assign bus.ovf       = gen_stg[NSTAGE-1].gen_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed, table-driven bench for pipelined_cla_adder (WIDTH=16, GPS=2, latency 2).
module tb_pipelined_cla_adder;

  localparam int WIDTH  = 16;
  localparam int GPS    = 2;
  localparam int NSTAGE = WIDTH / (4 * GPS);
  localparam int NVEC   = 13;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_cla_adder #(.WIDTH(WIDTH), .GPS(GPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prev_sum;
    logic        prev_stall;
    logic        acc_pending;
    int          sent;
    int          got;

    //              a         b         cin   sub   sum       cout  ovf
    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0};
    vecs[9]  = '{16'h0F00, 16'h0100, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[10] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[12] = '{16'h0007, 16'h0009, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.ain       = 16'h0000;
    bus.bin       = 16'h0000;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    #2;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.sum, 16'h0000);
    chk("rst_cout", bus.cout, 1'b0);
`ifdef CLA_OVF_EN
    chk("rst_ovf", bus.ovf, 1'b0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // Back-to-back streaming: vector c is driven at cycle c and must appear at cycle c+NSTAGE.
    for (int c = 0; c < NVEC + NSTAGE + 1; c++) begin
      tick();
      if (c >= NSTAGE && c < NVEC + NSTAGE) begin
        chk($sformatf("v%0d_valid", c - NSTAGE), bus.out_valid, 1'b1);
        chk($sformatf("v%0d_sum", c - NSTAGE), bus.sum, vecs[c - NSTAGE].s);
        chk($sformatf("v%0d_cout", c - NSTAGE), bus.cout, vecs[c - NSTAGE].co);
`ifdef CLA_OVF_EN
        chk($sformatf("v%0d_ovf", c - NSTAGE), bus.ovf, vecs[c - NSTAGE].ov);
`endif
      end else begin
        chk($sformatf("empty_valid_c%0d", c), bus.out_valid, 1'b0);
      end
      if (c < NVEC) begin
        bus.in_valid = 1'b1;
        bus.ain      = vecs[c].a;
        bus.bin      = vecs[c].b;
        bus.cin      = vecs[c].cin;
        bus.sub      = vecs[c].sub;
        chk($sformatf("stream_in_ready_c%0d", c), bus.in_ready, 1'b1);
      end else begin
        bus.in_valid = 1'b0;
      end
    end

    // Stall: ops 1+1..4+4 with out_ready low in cycles 3 and 4.
    sent        = 0;
    got         = 0;
    prev_stall  = 1'b0;
    prev_sum    = 16'h0000;
    acc_pending = 1'b0;
    bus.sub     = 1'b0;
    bus.cin     = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      if (acc_pending) sent++;
      #1;
      bus.out_ready = (c == 3 || c == 4) ? 1'b0 : 1'b1;
      #1;
      if (prev_stall) begin
        chk($sformatf("stall_hold_valid_c%0d", c), bus.out_valid, 1'b1);
        chk($sformatf("stall_hold_sum_c%0d", c), bus.sum, prev_sum);
      end
      if (bus.out_valid && !bus.out_ready)
        chk($sformatf("stall_in_ready_c%0d", c), bus.in_ready, 1'b0);
      if (c == 4)
        chk("stall_sum_c4", bus.sum, 16'h0004);
      if (bus.out_valid && bus.out_ready) begin
        if (got < 4) chk($sformatf("order_%0d", got), bus.sum, 2 * (got + 1));
        else         chk("extra_result", got, 4);
        got++;
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_sum   = bus.sum;
      if (sent < 4) begin
        bus.in_valid = 1'b1;
        bus.ain      = 16'(sent + 1);
        bus.bin      = 16'(sent + 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      acc_pending = bus.in_valid & bus.in_ready;
    end
    chk("stall_results", got, 4);
    chk("stall_accepted", sent, 4);

    // Reset with two ops in flight: they must vanish.
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    bus.ain      = 16'h0010;
    bus.bin      = 16'h0010;
    tick();
    bus.ain      = 16'h0020;
    bus.bin      = 16'h0020;
    tick();
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_sum", bus.sum, 16'h0000);
    chk("midrst_cout", bus.cout, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("postrst_valid_c%0d", c), bus.out_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
